// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// Shares one memory port between the CPU and a debug burst requester.
// Optional: `define ARB_STARVE_GUARD_EN to let debug preempt a busy CPU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_gnt,
   output logic              o_cpu_stall,
   output logic [DATA_W-1:0] o_cpu_rdata,
   input  logic              i_dbg_req,
   input  logic              i_dbg_we,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   input  logic [3:0]        i_dbg_len,
   input  logic [DATA_W-1:0] i_dbg_wdata,
   output logic              o_dbg_gnt,
   output logic              o_dbg_rvalid,
   output logic [DATA_W-1:0] o_dbg_rdata,
   output logic              o_dbg_done,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   typedef enum logic [0:0] {
      S_CPU_OWN = 1'b0,
      S_DBG_OWN = 1'b1
   } state_t;

   state_t            r_state;
   logic [4:0]        r_beats;
   logic [ADDR_W-1:0] r_addr;
   logic              r_done;
   logic              w_dbg_enter;

   if (STARVE_MAX < 1) begin : g_starve_max_invalid
   end

`ifdef ARB_STARVE_GUARD_EN
   localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
   localparam logic [SW-1:0] c_STARVE_LAST = SW'(STARVE_MAX - 1);
   logic [SW-1:0] r_starve;

   assign w_dbg_enter = i_dbg_req & (~i_cpu_req | (r_starve == c_STARVE_LAST));
`else
   assign w_dbg_enter = i_dbg_req & ~i_cpu_req;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_CPU_OWN;
         r_beats <= '0;
         r_addr  <= '0;
         r_done  <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
         r_starve <= '0;
`endif
      end else begin
         case (r_state)
            S_CPU_OWN: begin
               r_done <= 1'b0;
               if (w_dbg_enter) begin
                  r_state <= S_DBG_OWN;
                  r_addr  <= i_dbg_addr;
                  r_beats <= (i_dbg_len == 4'd0) ? 5'd16 : {1'b0, i_dbg_len};
               end
`ifdef ARB_STARVE_GUARD_EN
               // Counts consecutive cycles where debug waited behind the CPU.
               if (w_dbg_enter || !i_dbg_req) begin
                  r_starve <= '0;
               end else if (r_starve != c_STARVE_LAST) begin
                  r_starve <= r_starve + 1'b1;
               end
`endif
            end
            S_DBG_OWN: begin
               if (!i_dbg_req) begin
                  r_state <= S_CPU_OWN;
                  r_done  <= 1'b1;
               end else begin
                  r_addr  <= r_addr + 1'b1;
                  r_beats <= r_beats - 5'd1;
                  if (r_beats == 5'd1) begin
                     r_state <= S_CPU_OWN;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= S_CPU_OWN;
         endcase
      end
   end

   always_comb begin
      o_cpu_rdata = i_mem_rdata;
      o_dbg_rdata = i_mem_rdata;
      o_dbg_done  = r_done;
      if (r_state == S_DBG_OWN) begin
         o_cpu_gnt    = 1'b0;
         o_cpu_stall  = 1'b1;
         o_dbg_gnt    = i_dbg_req;
         o_dbg_rvalid = i_dbg_req & ~i_dbg_we;
         o_mem_addr   = r_addr;
         o_mem_we     = i_dbg_req & i_dbg_we;
         o_mem_wdata  = i_dbg_wdata;
      end else begin
         o_cpu_gnt    = i_cpu_req;
         o_cpu_stall  = 1'b0;
         o_dbg_gnt    = 1'b0;
         o_dbg_rvalid = 1'b0;
         o_mem_addr   = i_cpu_addr;
         o_mem_we     = i_cpu_req & i_cpu_we;
         o_mem_wdata  = i_cpu_wdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// Scoreboard bench: directed scenarios plus random traffic vs. an owner model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
   localparam int AW   = 8;
   localparam int DW   = 8;
   localparam int SMAX = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          dbg_req = 1'b0, dbg_we = 1'b0;
   logic [AW-1:0] dbg_addr = '0;
   logic [3:0]    dbg_len = '0;
   logic [DW-1:0] dbg_wdata = '0;
   logic          cpu_gnt, cpu_stall, dbg_gnt, dbg_rvalid, dbg_done, mem_we;
   logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return (a * 8'd7) ^ 8'h3C;
   endfunction

   assign mem_rdata = memf(mem_addr);

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
      .i_cpu_wdata(cpu_wdata), .o_cpu_gnt(cpu_gnt), .o_cpu_stall(cpu_stall),
      .o_cpu_rdata(cpu_rdata),
      .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
      .i_dbg_len(dbg_len), .i_dbg_wdata(dbg_wdata), .o_dbg_gnt(dbg_gnt),
      .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata), .o_dbg_done(dbg_done),
      .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
   );

   typedef struct {
      logic          cpu_gnt, stall, dbg_gnt, rvalid, done, we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: who owns the port, how long debug has waited, burst progress.
   bit            m_known = 0;
   bit            m_dbg_owns = 0;
   bit            m_done = 0;
   int            m_waited = 0;
   int            m_left = 0;
   logic [AW-1:0] m_next = '0;

   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit cr, input bit cw,
                       input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit dr, input bit dw, input logic [AW-1:0] da,
                       input logic [3:0] dl, input logic [DW-1:0] dd);
      exp_t e;
      bit   preempt;
      @(posedge clk);
      #1;
      rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_len = dl; dbg_wdata = dd;
      e.done = m_done;
      if (m_dbg_owns) begin
         e.cpu_gnt = 0; e.stall = 1; e.dbg_gnt = dr; e.rvalid = dr & !dw;
         e.we = dr & dw; e.addr = m_next; e.wdata = dd;
      end else begin
         e.cpu_gnt = cr; e.stall = 0; e.dbg_gnt = 0; e.rvalid = 0;
         e.we = cr & cw; e.addr = ca; e.wdata = cd;
      end
      if (m_known) q.push_back(e);
`ifdef ARB_STARVE_GUARD_EN
      preempt = (m_waited + 1 >= SMAX);
`else
      preempt = 0;
`endif
      if (!r) begin
         m_known = 1; m_dbg_owns = 0; m_done = 0; m_waited = 0; m_left = 0; m_next = '0;
      end else if (!m_dbg_owns) begin
         m_done = 0;
         if (dr && (!cr || preempt)) begin
            m_dbg_owns = 1; m_waited = 0; m_next = da;
            m_left = (dl == 0) ? 16 : int'(dl);
         end else if (dr) begin
            m_waited++;
         end else begin
            m_waited = 0;
         end
      end else if (dr) begin
         m_next = m_next + 1'b1;
         m_left--;
         if (m_left == 0) begin
            m_dbg_owns = 0; m_done = 1;
         end
      end else begin
         m_dbg_owns = 0; m_done = 1;
      end
   endtask

   exp_t me;
   always @(negedge clk) begin
      if (q.size() > 0) begin
         me = q.pop_front();
         chk("cpu_gnt",    8'(cpu_gnt),    8'(me.cpu_gnt));
         chk("cpu_stall",  8'(cpu_stall),  8'(me.stall));
         chk("dbg_gnt",    8'(dbg_gnt),    8'(me.dbg_gnt));
         chk("dbg_rvalid", 8'(dbg_rvalid), 8'(me.rvalid));
         chk("dbg_done",   8'(dbg_done),   8'(me.done));
         chk("mem_we",     8'(mem_we),     8'(me.we));
         chk("mem_addr",   mem_addr,       me.addr);
         chk("mem_wdata",  mem_wdata,      me.wdata);
         chk("cpu_rdata",  cpu_rdata,      memf(me.addr));
         chk("dbg_rdata",  dbg_rdata,      memf(me.addr));
      end
   end

   initial begin
      // Reset with CPU requesting at 0x12
      repeat (2) step(0, 1, 0, 8'h12, 8'h00, 0, 0, 8'h00, 4'd0, 8'h00);
      // Idle-CPU write burst of 3 at 0x10
      for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 4'd3, 8'(8'hA0 + i));
      repeat (2) step(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 4'd0, 8'h00);
      // Read burst of 16 wrapping from 0xFE
      for (int i = 0; i < 17; i++) step(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'hFE, 4'd0, 8'h00);
      repeat (2) step(1, 1, 0, 8'h33, 8'h00, 0, 0, 8'h00, 4'd0, 8'h00);
      // Busy CPU while debug waits
      for (int i = 0; i < 10; i++) step(1, 1, 1, 8'(8'h40 + i), 8'(i), 1, 1, 8'h80, 4'd2, 8'h5A);
      repeat (2) step(1, 1, 0, 8'h44, 8'h00, 0, 0, 8'h00, 4'd0, 8'h00);
      // Abort after two beats of an 8-beat write burst
      for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 4'd8, 8'(8'hC0 + i));
      repeat (3) step(1, 0, 0, 8'h00, 8'h00, 0, 1, 8'h20, 4'd8, 8'h00);
      // Reset during beat 3 of a 5-beat burst
      for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 4'd5, 8'(8'hD0 + i));
      step(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 4'd5, 8'hD3);
      repeat (3) step(1, 0, 0, 8'h00, 8'h00, 0, 1, 8'h30, 4'd5, 8'h00);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) != 0, $urandom_range(0, 99) < 60, 1'($urandom),
              8'($urandom), 8'($urandom), $urandom_range(0, 99) < 85, 1'($urandom),
              8'($urandom), 4'($urandom), 8'($urandom));
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between the processor core and the debug/programming requester. It sequences debug bursts with an auto-incrementing address and a starvation guard, and asserts `cpu_stall` so the top level can drop `processor_enable` while debug owns the port. It sits between the control unit's memory address/write path and the memory bank.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- STARVE_MAX, 4, consecutive contested cycles before debug preempts the CPU (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU access request (fetch, load, store)
- cpu_we  in  1  CPU write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_stall  out  1  CPU must hold; top gates `processor_enable` with `!cpu_stall`
- cpu_rdata  out  DATA_W  read data (= mem_rdata)
- dbg_req  in  1  debug burst request/continue
- dbg_we  in  1  debug burst is write
- dbg_addr  in  ADDR_W  burst start address, sampled on entry to DBG_OWN
- dbg_len  in  4  burst beats; 0 = 16
- dbg_wdata  in  DATA_W  write data for current beat
- dbg_gnt  out  1  debug beat performed this cycle
- dbg_rvalid  out  1  dbg_rdata valid (read beat)
- dbg_rdata  out  DATA_W  read data
- dbg_done  out  1  one-cycle pulse after a burst ends (complete or aborted)
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory combinational read data

## Operation
- FSM states: CPU_OWN (reset), DBG_OWN.
- CPU_OWN: cpu_gnt = cpu_req; mem_* driven from cpu_*; mem_we = cpu_req & cpu_we; cpu_stall = 0; dbg_gnt = 0.
  - Contested cycle (dbg_req & cpu_req): starve_cnt increments (saturating).
  - dbg_req low: starve_cnt cleared.
  - Switch to DBG_OWN at the edge when dbg_req & (!cpu_req | starve_cnt == STARVE_MAX-1).
  - On the switch: addr_ctr ← dbg_addr, beats ← (dbg_len==0 ? 16 : dbg_len), starve_cnt ← 0.
- DBG_OWN: cpu_stall = 1; cpu_gnt = 0; mem_addr = addr_ctr.
  - dbg_gnt = dbg_req.
  - mem_we = dbg_req & dbg_we; mem_wdata = dbg_wdata.
  - dbg_rvalid = dbg_gnt & !dbg_we.
  - Each granted beat: addr_ctr += 1 (wraps modulo 2^ADDR_W), beats -= 1.
- Burst end, then CPU_OWN next cycle with dbg_done = 1 for one cycle:
  - last beat granted (beats == 1), or
  - dbg_req low in DBG_OWN (abort; no access that cycle).
- dbg_we is sampled per beat. Changing it mid-burst is legal; the arbiter does not check it.
- In CPU_OWN with cpu_req low, mem_we = 0 and mem_addr = cpu_addr.
- Reset: state CPU_OWN, starve_cnt 0, beats 0, addr_ctr 0, dbg_done 0. The combinational outputs then follow the CPU_OWN rules, so cpu_stall = 0 and dbg_gnt = 0. A reset during a burst abandons it without a dbg_done pulse.

## Timing
- CPU access latency 0: cpu_gnt is combinational in CPU_OWN.
- Debug grant latency:
  - CPU idle: dbg_req sampled at edge N gives dbg_gnt in cycle N+1.
  - CPU continuously requesting: first dbg_gnt STARVE_MAX cycles after dbg_req rises.
- Simultaneous cpu_req and dbg_req in CPU_OWN: the CPU is granted that cycle.
- A full burst of L beats with dbg_req held gives exactly L consecutive dbg_gnt cycles.
- After any burst, at least one CPU_OWN cycle occurs before the next DBG_OWN.
- Read data for every grant is valid in the same cycle (combinational memory).

## Configuration
- `ARB_STARVE_GUARD_EN` defined: the starvation counter is present and behaves as above.
- Undefined: strict CPU priority, and debug enters DBG_OWN only when dbg_req & !cpu_req. The starve_cnt logic is removed and STARVE_MAX is ignored.

## Test plan
- Reset: rst=0 for 2 cycles with cpu_req=1 → cpu_gnt=1, cpu_stall=0, dbg_gnt=0, dbg_done=0; mem_addr tracks cpu_addr=0x12.
- Idle-CPU write burst: cpu_req=0, dbg_req=1, dbg_we=1, dbg_addr=0x10, dbg_len=3 → mem_we on 0x10/0x11/0x12 in cycles 1–3, dbg_done in cycle 4, cpu_stall=0 from cycle 4.
- Wrap and len=0: dbg_addr=0xFE, dbg_len=0, read → 16 beats at 0xFE, 0xFF, 0x00…0x0D; dbg_rvalid on each beat.
- Starvation (guard enabled, STARVE_MAX=4): cpu_req=1 constant, dbg_req rises at cycle 0 → first dbg_gnt at cycle 4, cpu_stall=1 during the burst. With the macro undefined → no dbg_gnt while cpu_req=1.
- Abort: burst len=8, dbg_req drops after beat 2 → no mem access that cycle, dbg_done next cycle, CPU_OWN restored, 2 writes total.
- Reset mid-burst at beat 3 of 5 → CPU_OWN the next cycle, cpu_stall=0, no dbg_done, no further debug writes.
